// File: rtl/int_ctrl_n_pkg.sv
// Shared types and address/vector constants for the per-core interrupt controller.
// Also holds small helpers used by the controller and its priority encoder.
package int_ctrl_n_pkg;

  typedef enum logic [1:0] {INT_IDLE, INT_REQ, INT_SVC} int_state_t;

  localparam logic [15:0] INT_EN         = 16'hC002;
  localparam logic [15:0] INT_PEND       = 16'hC003;
  localparam logic [15:0] INT_VEC_BASE   = 16'h0010;
  localparam logic [15:0] INT_VEC_STRIDE = 16'h0010;

  // Original fixed four-vector names kept for existing software headers.
  localparam logic [15:0] int0vec = INT_VEC_BASE;
  localparam logic [15:0] int1vec = INT_VEC_BASE + INT_VEC_STRIDE;
  localparam logic [15:0] int2vec = INT_VEC_BASE + 16'd2 * INT_VEC_STRIDE;
  localparam logic [15:0] int3vec = INT_VEC_BASE + 16'd3 * INT_VEC_STRIDE;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Handler address, computed modulo 2^16.
  function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                           input logic [15:0] stride,
                                           input logic [15:0] idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module int_prio_enc
  import int_ctrl_n_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  localparam int IDX_W = idx_width(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/int_ctrl_n.sv
// Per-core interrupt controller: MMIO enable/pending registers, edge or level
// sources, fixed-priority vector request and single-level service ended by RTI.
module int_ctrl_n
  import int_ctrl_n_pkg::*;
#(
  parameter int          NUM_IRQ    = 4,
  parameter logic [15:0] EDGE_MASK  = 16'h000F,
  parameter logic [15:0] VEC_BASE   = INT_VEC_BASE,
  parameter logic [15:0] VEC_STRIDE = INT_VEC_STRIDE,
  parameter logic [15:0] EN_ADDR    = INT_EN,
  parameter logic [15:0] PEND_ADDR  = INT_PEND
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [15:0]        addr,
  input  logic               we,
  input  logic               re,
  input  logic [15:0]        wdata,
  output logic [15:0]        rdata,
  output logic               int_req,
  output logic [15:0]        int_vec,
  input  logic               int_ack,
  input  logic               rti
);

  localparam int IDX_W = idx_width(NUM_IRQ);

  logic [NUM_IRQ-1:0] en;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] pend_nxt;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] wmask;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_valid;
  logic               en_wr;
  logic               w1c;
  logic               load;
  logic               ack_fire;
  int_state_t         state;
  int_state_t         state_nxt;

  assign wmask = NUM_IRQ'(wdata);
  assign en_wr = we && (addr == EN_ADDR);
  assign w1c   = we && (addr == PEND_ADDR);

  int_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .req   (pend & en),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // Edge sources: a new rising edge beats a same-cycle ack or W1C clear.
  always_comb begin
    pend_nxt = pend;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (EDGE_MASK[i]) begin
        if ((w1c && wmask[i]) || (ack_fire && (sel == IDX_W'(i)))) pend_nxt[i] = 1'b0;
        if (irq[i] && !irq_q[i]) pend_nxt[i] = 1'b1;
      end else begin
        pend_nxt[i] = irq[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en    <= '0;
      pend  <= '0;
      irq_q <= '0;
    end else begin
      irq_q <= irq;
      pend  <= pend_nxt;
      if (en_wr) en <= wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re && (addr == EN_ADDR)) begin
      rdata <= 16'(en);
    end else if (re && (addr == PEND_ADDR)) begin
      rdata <= 16'(pend);
    end else begin
      rdata <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INT_IDLE;
      sel     <= '0;
      int_vec <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        sel     <= enc_idx;
        int_vec <= vec_addr(VEC_BASE, VEC_STRIDE, 16'(enc_idx));
      end
    end
  end

  // Once in INT_REQ the request is committed; only int_ack moves it on.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ack_fire  = 1'b0;
    int_req   = 1'b0;
    unique case (state)
      INT_IDLE: begin
        if (enc_valid) begin
          state_nxt = INT_REQ;
          load      = 1'b1;
        end
      end
      INT_REQ: begin
        int_req = 1'b1;
        if (int_ack) begin
          state_nxt = INT_SVC;
          ack_fire  = 1'b1;
        end
      end
      INT_SVC: begin
        if (rti) state_nxt = INT_IDLE;
      end
      default: state_nxt = INT_IDLE;
    endcase
  end

endmodule
